// File: rtl/axi_lite_reg_sub_pkg.sv
// Shared response codes, channel FSM state encodings and index decode helper
// for the AXI4-Lite register subordinate.
package axi_lite_reg_sub_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_EXEC = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Register 0 is the read-only ID, so only writes to it are refused.
    function automatic logic [1:0] idx_resp(input int unsigned idx,
                                            input int unsigned num_regs,
                                            input logic        is_wr);
        if (idx >= num_regs)
            return RESP_DECERR;
        if (is_wr && idx == 0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_reg_sub_if.sv
// AXI4-Lite bus bundle (word-index addressing) with manager and subordinate views.
interface axi_lite_reg_sub_if #(
    parameter int ABUS_SIZE = 5,
    parameter int DBUS_SIZE = 32
);
    logic [ABUS_SIZE-1:0]   awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [DBUS_SIZE-1:0]   wdata;
    logic [DBUS_SIZE/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ABUS_SIZE-1:0]   araddr;
    logic                   arvalid;
    logic                   arready;
    logic [DBUS_SIZE-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_sub_regbank.sv
// Register array with byte-strobed write port and combinational read plus
// ID/range decode; register 0 is the constant ID and has no storage.
import axi_lite_reg_sub_pkg::*;

module axi_lite_reg_sub_regbank #(
    parameter int                   ABUS_SIZE = 5,
    parameter int                   DBUS_SIZE = 32,
    parameter int                   NUM_REGS  = 16,
    parameter logic [DBUS_SIZE-1:0] ID_VALUE  = 32'hA0A1_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ABUS_SIZE-1:0]   wr_idx,
    input  logic [DBUS_SIZE-1:0]   wr_data,
    input  logic [DBUS_SIZE/8-1:0] wr_strb,
    input  logic [ABUS_SIZE-1:0]   rd_idx,
    output logic [DBUS_SIZE-1:0]   rd_data,
    output logic [1:0]             rd_resp,
    output logic [1:0]             wr_resp
);
    localparam int NBYTES = DBUS_SIZE / 8;

    logic [DBUS_SIZE-1:0] regs [1:NUM_REGS-1];

    assign wr_resp = idx_resp(32'(wr_idx), NUM_REGS, 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en && wr_resp == RESP_OKAY) begin
            for (int i = 1; i < NUM_REGS; i++)
                for (int b = 0; b < NBYTES; b++)
                    if (wr_idx == ABUS_SIZE'(i) && wr_strb[b])
                        regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = idx_resp(32'(rd_idx), NUM_REGS, 1'b0);
        if (rd_idx == '0)
            rd_data = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++)
            if (rd_idx == ABUS_SIZE'(i))
                rd_data = regs[i];
    end

endmodule

// File: rtl/axi_lite_reg_sub.sv
// AXI4-Lite subordinate: independent write and read channel FSMs in front of
// a word-indexed register bank. All bus outputs are registered.
//   state  | meaning
//   W_IDLE | collecting AW and W, either order; each ready drops after its handshake
//   W_EXEC | one cycle: commit strobed bytes (OKAY only), latch BRESP
//   W_RESP | BVALID held with stable BRESP until BREADY
//   R_IDLE | ARREADY high, waiting for AR
//   R_DATA | RVALID held with stable RDATA/RRESP until RREADY
import axi_lite_reg_sub_pkg::*;

module axi_lite_reg_sub #(
    parameter int                   ABUS_SIZE = 5,
    parameter int                   DBUS_SIZE = 32,
    parameter int                   NUM_REGS  = 16,
    parameter logic [DBUS_SIZE-1:0] ID_VALUE  = 32'hA0A1_0001
) (
    input logic               clk,
    input logic               rst_n,
    axi_lite_reg_sub_if.slave bus
);
    logic [1:0]             w_state;
    logic                   aw_got, w_got;
    logic [ABUS_SIZE-1:0]   aw_idx;
    logic [DBUS_SIZE-1:0]   w_data;
    logic [DBUS_SIZE/8-1:0] w_strb;
    logic                   awready, wready, bvalid;
    logic [1:0]             bresp;

    logic [0:0]             r_state;
    logic                   arready, rvalid;
    logic [DBUS_SIZE-1:0]   rdata;
    logic [1:0]             rresp;

    logic [DBUS_SIZE-1:0]   rd_data;
    logic [1:0]             rd_resp, wr_resp;
    logic                   aw_hs, w_hs, ar_hs;

    assign aw_hs = bus.awvalid && awready;
    assign w_hs  = bus.wvalid && wready;
    assign ar_hs = bus.arvalid && arready;

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;

    axi_lite_reg_sub_regbank #(
        .ABUS_SIZE (ABUS_SIZE),
        .DBUS_SIZE (DBUS_SIZE),
        .NUM_REGS  (NUM_REGS),
        .ID_VALUE  (ID_VALUE)
    ) u_regbank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_state == W_EXEC),
        .wr_idx  (aw_idx),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (bus.araddr),
        .rd_data (rd_data),
        .rd_resp (rd_resp),
        .wr_resp (wr_resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got  <= 1'b1;
                        aw_idx  <= bus.awaddr;
                        awready <= 1'b0;
                    end else if (!aw_got) begin
                        awready <= 1'b1;
                    end
                    if (w_hs) begin
                        w_got  <= 1'b1;
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrb;
                        wready <= 1'b0;
                    end else if (!w_got) begin
                        wready <= 1'b1;
                    end
                    if ((aw_got || aw_hs) && (w_got || w_hs))
                        w_state <= W_EXEC;
                end
                W_EXEC: begin
                    bvalid  <= 1'b1;
                    bresp   <= wr_resp;
                    aw_got  <= 1'b0;
                    w_got   <= 1'b0;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // The bank read is combinational, so an AR landing on the W_EXEC edge sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata   <= rd_data;
                        rresp   <= rd_resp;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
